// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: IDLE -> ISSUE (-> RESP for reads) -> IDLE.
// Optional macro ARB_ROUND_ROBIN_EN: tie goes to the port not granted last; otherwise port A wins ties.
module ram_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reqA,
  input  logic              reqB,
  input  logic              weA,
  input  logic              weB,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] wdataA,
  input  logic [DATA_W-1:0] wdataB,
  output logic              gntA,
  output logic              gntB,
  output logic              rvalidA,
  output logic              rvalidB,
  output logic [DATA_W-1:0] rdataA,
  output logic [DATA_W-1:0] rdataB,
  output logic              busy,
  output logic              ram_writeOn,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e              state_r;
  state_e              next_state_s;
  logic                pick_b_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;

  logic                win_b_r;
  logic                cmd_we_r;
  logic                gnt_a_r;
  logic                gnt_b_r;
  logic                rvalid_a_r;
  logic                rvalid_b_r;
  logic [DATA_W-1:0]   rdata_a_r;
  logic [DATA_W-1:0]   rdata_b_r;
  logic                busy_r;
  logic                ram_we_r;
  logic [ADDR_W-1:0]   ram_addr_r;
  logic [DATA_W-1:0]   ram_wdata_r;
`ifdef ARB_ROUND_ROBIN_EN
  logic                last_b_r;
`endif

  // Winner selection and the winner's command fields.
  always_comb begin
    pick_b_s = 1'b0;
    if (reqA && reqB) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick_b_s = ~last_b_r;
`else
      pick_b_s = 1'b0;
`endif
    end else begin
      pick_b_s = reqB;
    end
    if (pick_b_s) begin
      sel_we_s    = weB;
      sel_addr_s  = addrB;
      sel_wdata_s = wdataB;
    end else begin
      sel_we_s    = weA;
      sel_addr_s  = addrA;
      sel_wdata_s = wdataA;
    end
  end

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (reqA || reqB) begin
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_we_r) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RESP;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered outputs: gnt and ram_writeOn are set only for the ISSUE cycle, rvalid for the cycle after RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_b_r     <= 1'b0;
      cmd_we_r    <= 1'b0;
      gnt_a_r     <= 1'b0;
      gnt_b_r     <= 1'b0;
      rvalid_a_r  <= 1'b0;
      rvalid_b_r  <= 1'b0;
      rdata_a_r   <= {DATA_W{1'b0}};
      rdata_b_r   <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= {DATA_W{1'b0}};
    end else begin
      gnt_a_r    <= 1'b0;
      gnt_b_r    <= 1'b0;
      rvalid_a_r <= 1'b0;
      rvalid_b_r <= 1'b0;
      ram_we_r   <= 1'b0;
      busy_r     <= (next_state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (reqA || reqB) begin
            win_b_r     <= pick_b_s;
            cmd_we_r    <= sel_we_s;
            ram_we_r    <= sel_we_s;
            ram_addr_r  <= sel_addr_s;
            ram_wdata_r <= sel_wdata_s;
            gnt_a_r     <= ~pick_b_s;
            gnt_b_r     <= pick_b_s;
          end
        end
        RESP: begin
          if (win_b_r) begin
            rdata_b_r  <= ram_data_out;
            rvalid_b_r <= 1'b1;
          end else begin
            rdata_a_r  <= ram_data_out;
            rvalid_a_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which port was granted most recently; B after reset so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_r <= 1'b1;
    end else if (state_r == IDLE && (reqA || reqB)) begin
      last_b_r <= pick_b_s;
    end else begin
      last_b_r <= last_b_r;
    end
  end
`endif

  assign gntA        = gnt_a_r;
  assign gntB        = gnt_b_r;
  assign rvalidA     = rvalid_a_r;
  assign rvalidB     = rvalid_b_r;
  assign rdataA      = rdata_a_r;
  assign rdataB      = rdata_b_r;
  assign busy        = busy_r;
  assign ram_writeOn = ram_we_r;
  assign ram_address = ram_addr_r;
  assign ram_data_in = ram_wdata_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural synchronous RAM.
// Expected tie-break order follows ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_ram_arbiter;

  logic        clk_tb;
  logic        rst_n;
  logic        reqA, reqB, weA, weB;
  logic [5:0]  addrA, addrB;
  logic [31:0] wdataA, wdataB;
  logic        gntA, gntB, rvalidA, rvalidB, busy, ram_writeOn;
  logic [31:0] rdataA, rdataB, ram_data_in, ram_data_out;
  logic [5:0]  ram_address;
  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rd_a = 32'h0;
  logic [31:0] exp_rd_b = 32'h0;

  ram_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk_tb), .rst_n(rst_n),
    .reqA(reqA), .reqB(reqB), .weA(weA), .weB(weB),
    .addrA(addrA), .addrB(addrB), .wdataA(wdataA), .wdataB(wdataB),
    .gntA(gntA), .gntB(gntB), .rvalidA(rvalidA), .rvalidB(rvalidB),
    .rdataA(rdataA), .rdataB(rdataB), .busy(busy),
    .ram_writeOn(ram_writeOn), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  // Synchronous RAM: data_out registered on the edge that samples the address.
  always @(posedge clk_tb) begin
    if (ram_writeOn) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit port_b, input bit we, input logic [5:0] addr, input logic [31:0] data);
    if (port_b) begin
      reqB = 1'b1; weB = we; addrB = addr; wdataB = data;
    end else begin
      reqA = 1'b1; weA = we; addrA = addr; wdataA = data;
    end
  endtask

  task automatic do_write(input bit port_b, input logic [5:0] addr, input logic [31:0] data);
    @(negedge clk_tb);
    drive(port_b, 1'b1, addr, data);
    @(negedge clk_tb);
    check_eq("wr_gnt", {gntB, gntA}, port_b ? 64'd2 : 64'd1);
    check_eq("wr_we", ram_writeOn, 1);
    check_eq("wr_addr", ram_address, addr);
    check_eq("wr_data", ram_data_in, data);
    check_eq("wr_busy", busy, 1);
    reqA = 1'b0; reqB = 1'b0;
    @(negedge clk_tb);
    check_eq("wr_done_gnt", {gntB, gntA, busy, ram_writeOn}, 0);
    check_eq("wr_addr_hold", ram_address, addr);
  endtask

  task automatic do_read(input bit port_b, input logic [5:0] addr, input logic [31:0] exp);
    @(negedge clk_tb);
    drive(port_b, 1'b0, addr, 32'h0);
    @(negedge clk_tb);
    check_eq("rd_gnt", {gntB, gntA}, port_b ? 64'd2 : 64'd1);
    check_eq("rd_we", ram_writeOn, 0);
    check_eq("rd_addr", ram_address, addr);
    reqA = 1'b0; reqB = 1'b0;
    @(negedge clk_tb);
    check_eq("rd_resp", {busy, ram_writeOn, rvalidB, rvalidA}, 64'h8);
    check_eq("rd_resp_addr", ram_address, addr);
    @(negedge clk_tb);
    if (port_b) exp_rd_b = exp; else exp_rd_a = exp;
    check_eq("rd_rvalid", {rvalidB, rvalidA}, port_b ? 64'd2 : 64'd1);
    check_eq("rd_busy", busy, 0);
    check_eq("rd_dataA", rdataA, exp_rd_a);
    check_eq("rd_dataB", rdataB, exp_rd_b);
    @(negedge clk_tb);
    check_eq("rd_rvalid_end", {rvalidB, rvalidA}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g [0:3];
    int n;
    bit saw;
    bit who;
    rst_n = 1'b0;
    reqA = 1'b0; reqB = 1'b0; weA = 1'b0; weB = 1'b0;
    addrA = 6'd0; addrB = 6'd0; wdataA = 32'h0; wdataB = 32'h0;
    repeat (2) @(negedge clk_tb);
    check_eq("rst_ctrl", {gntA, gntB, rvalidA, rvalidB, busy, ram_writeOn}, 0);
    check_eq("rst_data", {rdataA, rdataB}, 0);
    check_eq("rst_ram", {ram_address, ram_data_in}, 0);
    rst_n = 1'b1;

    // Single write then read-back on the other port.
    do_write(1'b0, 6'd5, 32'hDEADBEEF);
    do_read(1'b1, 6'd5, 32'hDEADBEEF);

    // Tie: both ports hold write requests.
    @(negedge clk_tb);
    reqA = 1'b1; weA = 1'b1; addrA = 6'd1; wdataA = 32'h1111_0001;
    reqB = 1'b1; weB = 1'b1; addrB = 6'd2; wdataB = 32'h2222_0002;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk_tb);
      if (gntA) begin g[n] = 1'b0; n++; end
      else if (gntB) begin g[n] = 1'b1; n++; end
    end
    check_eq("tie_count", n, 4);
`ifdef ARB_ROUND_ROBIN_EN
    check_eq("tie_g0", g[0], 0);
    check_eq("tie_g1", g[1], 1);
    check_eq("tie_g2", g[2], 0);
    check_eq("tie_g3", g[3], 1);
`else
    check_eq("tie_g0", g[0], 0);
    check_eq("tie_g1", g[1], 0);
    check_eq("tie_g2", g[2], 0);
    check_eq("tie_g3", g[3], 0);
`endif
    reqA = 1'b0;
    saw = 1'b0; who = 1'b0;
    for (int i = 0; i < 10 && !saw; i++) begin
      @(negedge clk_tb);
      if (gntA || gntB) begin saw = 1'b1; who = gntB; end
    end
    check_eq("tie_b_served", {saw, who}, 64'd3);
    reqB = 1'b0;
    @(negedge clk_tb);
    do_read(1'b0, 6'd1, 32'h1111_0001);
    do_read(1'b0, 6'd2, 32'h2222_0002);

    // Reset during a write ISSUE must block the RAM write.
    do_write(1'b1, 6'd9, 32'hCAFE_0009);
    @(negedge clk_tb);
    drive(1'b0, 1'b1, 6'd9, 32'h12345678);
    @(posedge clk_tb);
    #2;
    check_eq("pre_rst_we", ram_writeOn, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ctrl", {gntA, gntB, rvalidA, rvalidB, busy, ram_writeOn}, 0);
    check_eq("mid_rst_data", {rdataA, rdataB}, 0);
    check_eq("mid_rst_ram", {ram_address, ram_data_in}, 0);
    reqA = 1'b0;
    exp_rd_a = 32'h0; exp_rd_b = 32'h0;
    @(negedge clk_tb);
    @(negedge clk_tb);
    rst_n = 1'b1;
    do_read(1'b0, 6'd9, 32'hCAFE_0009);

    // Address boundaries.
    do_write(1'b1, 6'd0, 32'h0BAD_0BAD);
    do_write(1'b0, 6'd63, 32'hFFFFFFFF);
    do_write(1'b1, 6'd0, 32'h0);
    do_read(1'b0, 6'd63, 32'hFFFFFFFF);
    do_read(1'b1, 6'd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
